mem_stage: RTL and testbench

//   Memory stage; consumes the ALU/MEM pipeline buffer outputs. Performs data-RAM loads/stores, owns the stack pointer (SP), and does 32-bit PC push/pop (call/ret/int) as two 16-bit word accesses.

---
 rtl/mem_stage.sv | 140 ++++++++++++++
 tb/tb_mem_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: data-RAM load/store, stack pointer, 32-bit PC push/pop as two 16-bit word accesses.
// Latency 1 for single-word ops, 2 for wide ops; o_stall freezes upstream during the first wide cycle.
module mem_stage #(
    parameter int WbSize  = 4,
    parameter int MemSize = 6,
    parameter int AddrW   = 12,
    parameter logic [AddrW-1:0] SP_INIT = {AddrW{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic [MemSize-1:0] i_Mem,
    input  logic [WbSize-1:0]  i_WB,
    input  logic [31:0]        i_pc,
    input  logic [2:0]         i_Rdst,
    input  logic [15:0]        i_alu,
    input  logic [15:0]        i_read_data1,
    input  logic [15:0]        i_ram_rdata,
    output logic [AddrW-1:0]   o_ram_addr,
    output logic [15:0]        o_ram_wdata,
    output logic               o_ram_we,
    output logic [WbSize-1:0]  o_WB,
    output logic [2:0]         o_Rdst,
    output logic [15:0]        o_alu,
    output logic [15:0]        o_mem_data,
    output logic [31:0]        o_pc_restore,
    output logic               o_pc_load,
    output logic               o_stall,
    output logic               o_stack_err
);

    typedef enum logic {IDLE, WIDE2} state_t;

    state_t           state, state_nxt;
    logic [AddrW-1:0] sp, sp_nxt;
    logic [15:0]      pc_lo_q, pop_lo_q;
    logic             wide_pop_q;
    logic             mem_read, mem_write, stack, wide, memop, go, start_wide;
    logic             push_step, pop_step, err_set;

    wire unused_bits = ^{i_Mem[MemSize-1:4], i_alu[15:AddrW]};

    assign mem_read   = i_Mem[0];
    assign mem_write  = i_Mem[1];
    assign stack      = i_Mem[2];
    assign wide       = i_Mem[3];
    assign memop      = mem_read ^ mem_write;
    assign go         = i_enable & ~rst;
    assign start_wide = (state == IDLE) & stack & wide & memop;

    always_comb begin
        state_nxt   = state;
        sp_nxt      = sp;
        o_ram_addr  = i_alu[AddrW-1:0];
        o_ram_wdata = i_read_data1;
        o_ram_we    = 1'b0;
        o_stall     = 1'b0;
        err_set     = 1'b0;
        push_step   = 1'b0;
        pop_step    = 1'b0;
        if (go) begin
            if (state == WIDE2) begin
                state_nxt = IDLE;
                if (wide_pop_q) begin
                    pop_step = 1'b1;
                end else begin
                    push_step   = 1'b1;
                    o_ram_wdata = pc_lo_q;
                end
            end else if (memop) begin
                if (stack) begin
                    push_step = mem_write;
                    pop_step  = mem_read;
                    if (wide) begin
                        state_nxt = WIDE2;
                        o_stall   = 1'b1;
                        if (mem_write) o_ram_wdata = i_pc[31:16];
                    end
                end else begin
                    o_ram_we = mem_write;
                end
            end
            // Push writes at SP then decrements; pop pre-increments and reads.
            if (push_step) begin
                o_ram_addr = sp;
                o_ram_we   = 1'b1;
                sp_nxt     = sp - AddrW'(1);
                err_set    = (sp == '0);
            end
            if (pop_step) begin
                o_ram_addr = sp + AddrW'(1);
                sp_nxt     = sp + AddrW'(1);
                err_set    = (sp == SP_INIT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sp           <= SP_INIT;
            pc_lo_q      <= '0;
            pop_lo_q     <= '0;
            wide_pop_q   <= 1'b0;
            o_WB         <= '0;
            o_Rdst       <= '0;
            o_alu        <= '0;
            o_mem_data   <= '0;
            o_pc_restore <= '0;
            o_pc_load    <= 1'b0;
            o_stack_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            sp    <= sp_nxt;
            if (err_set) o_stack_err <= 1'b1;
            if (i_enable) begin
                o_Rdst     <= i_Rdst;
                o_alu      <= i_alu;
                o_pc_load  <= 1'b0;
                o_mem_data <= '0;
                if (state == WIDE2) begin
                    o_WB <= i_WB;
                    if (wide_pop_q) begin
                        o_pc_restore <= {i_ram_rdata, pop_lo_q};
                        o_pc_load    <= 1'b1;
                    end
                end else if (start_wide) begin
                    o_WB       <= '0;
                    pc_lo_q    <= i_pc[15:0];
                    pop_lo_q   <= i_ram_rdata;
                    wide_pop_q <= mem_read;
                end else begin
                    o_WB <= i_WB;
                    if (memop && mem_read) o_mem_data <= i_ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural 4K x 16 data RAM.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [5:0]  i_Mem;
    logic [3:0]  i_WB;
    logic [31:0] i_pc;
    logic [2:0]  i_Rdst;
    logic [15:0] i_alu, i_read_data1, i_ram_rdata;
    logic [11:0] o_ram_addr;
    logic [15:0] o_ram_wdata;
    logic        o_ram_we;
    logic [3:0]  o_WB;
    logic [2:0]  o_Rdst;
    logic [15:0] o_alu, o_mem_data;
    logic [31:0] o_pc_restore;
    logic        o_pc_load, o_stall, o_stack_err;

    logic [15:0] ram [0:4095];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign i_ram_rdata = ram[o_ram_addr];
    always @(posedge clk) if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;

    mem_stage dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_Mem(i_Mem), .i_WB(i_WB),
        .i_pc(i_pc), .i_Rdst(i_Rdst), .i_alu(i_alu), .i_read_data1(i_read_data1),
        .i_ram_rdata(i_ram_rdata), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
        .o_ram_we(o_ram_we), .o_WB(o_WB), .o_Rdst(o_Rdst), .o_alu(o_alu),
        .o_mem_data(o_mem_data), .o_pc_restore(o_pc_restore), .o_pc_load(o_pc_load),
        .o_stall(o_stall), .o_stack_err(o_stack_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
        ram[0] = 16'h1234;
        rst = 1'b1; i_enable = 1'b1; i_Mem = 6'b000010; i_WB = 4'h0; i_pc = 32'h0;
        i_Rdst = 3'd0; i_alu = 16'h0010; i_read_data1 = 16'hBEEF;
        #3;
        chk("rst_we", o_ram_we, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_wb", o_WB, 0);
        chk("rst_memdata", o_mem_data, 0);
        chk("rst_pcload", o_pc_load, 0);
        chk("rst_pcrestore", o_pc_restore, 0);
        chk("rst_err", o_stack_err, 0);
        step();
        rst = 1'b0;

        // single store
        i_Mem = 6'b000010; i_WB = 4'hA; i_Rdst = 3'd5; i_alu = 16'h0010; i_read_data1 = 16'hBEEF;
        #1;
        chk("st_we", o_ram_we, 1);
        chk("st_addr", o_ram_addr, 12'h010);
        chk("st_wdata", o_ram_wdata, 16'hBEEF);
        chk("st_stall", o_stall, 0);
        step();
        chk("st_wb", o_WB, 4'hA);
        chk("st_rdst", o_Rdst, 3'd5);
        chk("st_alu", o_alu, 16'h0010);

        // single load of the stored word
        i_Mem = 6'b000001; i_WB = 4'h3;
        #1;
        chk("ld_we", o_ram_we, 0);
        chk("ld_addr", o_ram_addr, 12'h010);
        step();
        chk("ld_data", o_mem_data, 16'hBEEF);
        chk("ld_wb", o_WB, 4'h3);

        // read and write both set: plain ALU op
        i_Mem = 6'b000111;
        #1;
        chk("both_we", o_ram_we, 0);
        chk("both_stall", o_stall, 0);
        step();
        chk("both_data", o_mem_data, 0);

        // wide push of PC
        i_Mem = 6'b001110; i_pc = 32'h0001_2345; i_WB = 4'h5;
        #1;
        chk("wpush0_addr", o_ram_addr, 12'hFFF);
        chk("wpush0_wdata", o_ram_wdata, 16'h0001);
        chk("wpush0_we", o_ram_we, 1);
        chk("wpush0_stall", o_stall, 1);
        step();
        chk("wpush0_wb", o_WB, 0);
        #1;
        chk("wpush1_addr", o_ram_addr, 12'hFFE);
        chk("wpush1_wdata", o_ram_wdata, 16'h2345);
        chk("wpush1_we", o_ram_we, 1);
        chk("wpush1_stall", o_stall, 0);
        step();
        chk("wpush1_wb", o_WB, 4'h5);
        chk("wpush1_pcload", o_pc_load, 0);

        // wide pop with an enable hold between the two words
        i_Mem = 6'b001101;
        #1;
        chk("wpop0_addr", o_ram_addr, 12'hFFE);
        chk("wpop0_we", o_ram_we, 0);
        chk("wpop0_stall", o_stall, 1);
        step();
        chk("wpop0_wb", o_WB, 0);
        i_enable = 1'b0;
        #1;
        chk("hold_stall", o_stall, 0);
        chk("hold_we", o_ram_we, 0);
        step();
        chk("hold_wb", o_WB, 0);
        chk("hold_pcload", o_pc_load, 0);
        i_enable = 1'b1;
        #1;
        chk("wpop1_addr", o_ram_addr, 12'hFFF);
        chk("wpop1_stall", o_stall, 0);
        step();
        chk("wpop_pc", o_pc_restore, 32'h0001_2345);
        chk("wpop_pcload", o_pc_load, 1);
        chk("wpop_wb", o_WB, 4'h5);

        // single pop at SP=0xFFF underflows and wraps to 0
        i_Mem = 6'b000101; i_WB = 4'h6;
        #1;
        chk("upop_addr", o_ram_addr, 12'h000);
        step();
        chk("upop_pcload", o_pc_load, 0);
        chk("upop_data", o_mem_data, 16'h1234);
        chk("upop_err", o_stack_err, 1);

        // single push at SP=0 wraps back to 0xFFF
        i_Mem = 6'b000110; i_read_data1 = 16'h7777;
        #1;
        chk("opush_addr", o_ram_addr, 12'h000);
        chk("opush_wdata", o_ram_wdata, 16'h7777);
        chk("opush_we", o_ram_we, 1);
        step();
        chk("opush_err", o_stack_err, 1);

        // reset while in the second cycle of a wide push
        i_Mem = 6'b001110; i_pc = 32'hCAFE_0000;
        #1;
        chk("rpush0_addr", o_ram_addr, 12'hFFF);
        chk("rpush0_wdata", o_ram_wdata, 16'hCAFE);
        chk("rpush0_stall", o_stall, 1);
        step();
        rst = 1'b1;
        #1;
        chk("rmid_we", o_ram_we, 0);
        chk("rmid_stall", o_stall, 0);
        chk("rmid_err", o_stack_err, 0);
        chk("rmid_wb", o_WB, 0);
        step();
        chk("rmid_ram", ram[12'hFFE], 16'h2345);
        rst = 1'b0;
        i_Mem = 6'b000110; i_read_data1 = 16'h5555;
        #1;
        chk("rpost_addr", o_ram_addr, 12'hFFF);
        chk("rpost_stall", o_stall, 0);
        step();
        i_Mem = 6'b000000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
